// File: rtl/id_ex_ctrl_stage.sv
// id_ex_ctrl_stage: ID/EX pipeline register for the decoder control word.
// Injects bubbles on a wrong-path flush and on a load-use hazard (single-cycle
// stall), and keeps a saturating count of the bubbles it inserted.
// Build option: define ID_EX_HAZARD_DETECT_EN to enable load-use detection.
// Without it the hazard is tied off, stall is constant 0 and STALL is never
// entered; load-use spacing is then left to software.
//
// state    | meaning
// RST_IDLE | first edge after reset; loads a bubble, never stalls
// RUN      | normal operation; may stall on a load-use hazard
// STALL    | one bubble already issued; held instruction loads next edge
module id_ex_ctrl_stage (
  input  logic        i_clk,
  input  logic        i_arst,
  input  logic        i_id_valid,
  input  logic [1:0]  i_id_alu_op,
  input  logic        i_id_reg_dst,
  input  logic        i_id_branch,
  input  logic        i_id_mem_read,
  input  logic        i_id_mem_2_reg,
  input  logic        i_id_mem_write,
  input  logic        i_id_alu_src,
  input  logic        i_id_reg_write,
  input  logic        i_id_jump,
  input  logic [4:0]  i_id_rs1,
  input  logic [4:0]  i_id_rs2,
  input  logic [4:0]  i_id_rd,
  input  logic        i_ex_flush,
  output logic [1:0]  o_ex_alu_op,
  output logic        o_ex_reg_dst,
  output logic        o_ex_branch,
  output logic        o_ex_mem_read,
  output logic        o_ex_mem_2_reg,
  output logic        o_ex_mem_write,
  output logic        o_ex_alu_src,
  output logic        o_ex_reg_write,
  output logic        o_ex_jump,
  output logic [4:0]  o_ex_rd,
  output logic        o_ex_valid,
  output logic        o_stall,
  output logic [15:0] o_bubble_cnt
);

  typedef enum logic [1:0] {
    RST_IDLE = 2'b00,
    RUN      = 2'b01,
    STALL    = 2'b10
  } state_t;

  state_t r_state;
  state_t w_state_nxt;
  logic   w_hz;
  logic   w_bubble;
  logic   w_count;

`ifdef ID_EX_HAZARD_DETECT_EN
  // x0 is never a real producer, so a load targeting it cannot create a hazard
  assign w_hz = o_ex_valid & o_ex_mem_read & (o_ex_rd != 5'd0) & i_id_valid &
                ((o_ex_rd == i_id_rs1) | (o_ex_rd == i_id_rs2));
`else
  logic w_unused_rs;
  assign w_unused_rs = ^{i_id_rs1, i_id_rs2};
  assign w_hz = 1'b0;
`endif

  // State register
  always_ff @(posedge i_clk or posedge i_arst) begin
    if (i_arst) r_state <= RST_IDLE;
    else        r_state <= w_state_nxt;
  end

  // Next-state logic: flush always returns to RUN; STALL lasts one cycle
  always_comb begin
    w_state_nxt = RUN;
    case (r_state)
      RST_IDLE: w_state_nxt = RUN;
      RUN:      w_state_nxt = (o_stall) ? STALL : RUN;
      STALL:    w_state_nxt = RUN;
      default:  w_state_nxt = RST_IDLE;
    endcase
  end

  // Outputs: stall only from RUN, flush overrides it; decide bubble and counting
  always_comb begin
    o_stall  = w_hz & ~i_ex_flush & (r_state == RUN);
    w_bubble = (r_state == RST_IDLE) | i_ex_flush | o_stall;
    w_count  = (r_state != RST_IDLE) & (i_ex_flush | o_stall);
  end

  // ID/EX control register: bubble clears everything, otherwise pass decode word
  always_ff @(posedge i_clk or posedge i_arst) begin
    if (i_arst) begin
      o_ex_alu_op    <= 2'b00;
      o_ex_reg_dst   <= 1'b0;
      o_ex_branch    <= 1'b0;
      o_ex_mem_read  <= 1'b0;
      o_ex_mem_2_reg <= 1'b0;
      o_ex_mem_write <= 1'b0;
      o_ex_alu_src   <= 1'b0;
      o_ex_reg_write <= 1'b0;
      o_ex_jump      <= 1'b0;
      o_ex_rd        <= 5'd0;
      o_ex_valid     <= 1'b0;
    end else if (w_bubble) begin
      o_ex_alu_op    <= 2'b00;
      o_ex_reg_dst   <= 1'b0;
      o_ex_branch    <= 1'b0;
      o_ex_mem_read  <= 1'b0;
      o_ex_mem_2_reg <= 1'b0;
      o_ex_mem_write <= 1'b0;
      o_ex_alu_src   <= 1'b0;
      o_ex_reg_write <= 1'b0;
      o_ex_jump      <= 1'b0;
      o_ex_rd        <= 5'd0;
      o_ex_valid     <= 1'b0;
    end else begin
      o_ex_alu_op    <= i_id_alu_op;
      o_ex_reg_dst   <= i_id_reg_dst;
      o_ex_branch    <= i_id_branch;
      o_ex_mem_read  <= i_id_mem_read;
      o_ex_mem_2_reg <= i_id_mem_2_reg;
      o_ex_mem_write <= i_id_mem_write;
      o_ex_alu_src   <= i_id_alu_src;
      o_ex_reg_write <= i_id_reg_write;
      o_ex_jump      <= i_id_jump;
      o_ex_rd        <= i_id_rd;
      o_ex_valid     <= i_id_valid;
    end
  end

  // Saturating bubble counter; the reset-time bubble is not counted
  always_ff @(posedge i_clk or posedge i_arst) begin
    if (i_arst)                               o_bubble_cnt <= 16'd0;
    else if (w_count && o_bubble_cnt != 16'hFFFF) o_bubble_cnt <= o_bubble_cnt + 16'd1;
  end

endmodule

// File: tb/tb_id_ex_ctrl_stage.sv
// Directed bench for id_ex_ctrl_stage with an expected-result queue.
// Expectations follow the hazard build option (ID_EX_HAZARD_DETECT_EN).
module tb_id_ex_ctrl_stage;

`ifdef ID_EX_HAZARD_DETECT_EN
  localparam bit HZ_EN = 1'b1;
`else
  localparam bit HZ_EN = 1'b0;
`endif

  logic        i_clk = 1'b0;
  logic        i_arst = 1'b1;
  logic        i_id_valid = 1'b0;
  logic [1:0]  i_id_alu_op = 2'b00;
  logic        i_id_reg_dst = 1'b0, i_id_branch = 1'b0, i_id_mem_read = 1'b0, i_id_mem_2_reg = 1'b0;
  logic        i_id_mem_write = 1'b0, i_id_alu_src = 1'b0, i_id_reg_write = 1'b0, i_id_jump = 1'b0;
  logic [4:0]  i_id_rs1 = 5'd0, i_id_rs2 = 5'd0, i_id_rd = 5'd0;
  logic        i_ex_flush = 1'b0;
  logic [1:0]  o_ex_alu_op;
  logic        o_ex_reg_dst, o_ex_branch, o_ex_mem_read, o_ex_mem_2_reg;
  logic        o_ex_mem_write, o_ex_alu_src, o_ex_reg_write, o_ex_jump;
  logic [4:0]  o_ex_rd;
  logic        o_ex_valid, o_stall;
  logic [15:0] o_bubble_cnt;

  id_ex_ctrl_stage dut (
    .i_clk(i_clk), .i_arst(i_arst), .i_id_valid(i_id_valid),
    .i_id_alu_op(i_id_alu_op), .i_id_reg_dst(i_id_reg_dst), .i_id_branch(i_id_branch),
    .i_id_mem_read(i_id_mem_read), .i_id_mem_2_reg(i_id_mem_2_reg),
    .i_id_mem_write(i_id_mem_write), .i_id_alu_src(i_id_alu_src),
    .i_id_reg_write(i_id_reg_write), .i_id_jump(i_id_jump),
    .i_id_rs1(i_id_rs1), .i_id_rs2(i_id_rs2), .i_id_rd(i_id_rd),
    .i_ex_flush(i_ex_flush),
    .o_ex_alu_op(o_ex_alu_op), .o_ex_reg_dst(o_ex_reg_dst), .o_ex_branch(o_ex_branch),
    .o_ex_mem_read(o_ex_mem_read), .o_ex_mem_2_reg(o_ex_mem_2_reg),
    .o_ex_mem_write(o_ex_mem_write), .o_ex_alu_src(o_ex_alu_src),
    .o_ex_reg_write(o_ex_reg_write), .o_ex_jump(o_ex_jump),
    .o_ex_rd(o_ex_rd), .o_ex_valid(o_ex_valid), .o_stall(o_stall),
    .o_bubble_cnt(o_bubble_cnt)
  );

  always #5 i_clk = ~i_clk;

  // bit order of the 8 flags: reg_dst branch mem_read mem_2_reg mem_write alu_src reg_write jump
  localparam logic [7:0] F_LW  = 8'b0011_0110;
  localparam logic [7:0] F_ADD = 8'b1000_0010;
  localparam logic [7:0] F_SW  = 8'b0000_1100;
  localparam logic [7:0] F_BEQ = 8'b0100_0000;

  typedef struct packed {
    logic [15:0] word;
    logic [15:0] cnt;
  } exp_t;

  exp_t        sb[$];
  int          n_assert = 0;
  int          n_fail = 0;
  logic [15:0] exp_cnt = 16'd0;
  bit          idle = 1'b0;
  logic [15:0] w_obs;

  assign w_obs = {o_ex_alu_op, o_ex_reg_dst, o_ex_branch, o_ex_mem_read, o_ex_mem_2_reg,
                  o_ex_mem_write, o_ex_alu_src, o_ex_reg_write, o_ex_jump, o_ex_rd, o_ex_valid};

  task automatic check(input string tag, input logic [15:0] obs, input logic [15:0] exp);
    n_assert++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  // Starts at a falling edge: drive, check stall, push expectation, clock, pop and compare.
  task automatic step(input string tag, input logic [1:0] alu, input logic [7:0] fl_bits,
                      input logic [4:0] rs1, input logic [4:0] rs2, input logic [4:0] rd,
                      input logic v, input logic flush, input logic hz);
    logic  exp_stall;
    logic  bub;
    exp_t  e;
    exp_t  got;
    i_id_alu_op = alu;
    {i_id_reg_dst, i_id_branch, i_id_mem_read, i_id_mem_2_reg,
     i_id_mem_write, i_id_alu_src, i_id_reg_write, i_id_jump} = fl_bits;
    i_id_rs1 = rs1; i_id_rs2 = rs2; i_id_rd = rd;
    i_id_valid = v; i_ex_flush = flush;
    #1;
    exp_stall = HZ_EN && hz && !flush && !idle;
    check({tag, "_stall"}, {15'd0, o_stall}, {15'd0, exp_stall});
    bub = flush | exp_stall | idle;
    if (bub && !idle && exp_cnt != 16'hFFFF) exp_cnt = exp_cnt + 16'd1;
    e.word = bub ? 16'h0000 : {alu, fl_bits, rd, v};
    e.cnt  = exp_cnt;
    sb.push_back(e);
    idle = 1'b0;
    @(posedge i_clk);
    #1;
    if (sb.size() == 0) begin
      check({tag, "_sb_empty"}, 16'd1, 16'd0);
    end else begin
      got = sb.pop_front();
      check({tag, "_ex"}, w_obs, got.word);
      check({tag, "_cnt"}, o_bubble_cnt, got.cnt);
    end
    @(negedge i_clk);
  endtask

  task automatic check_reset_outputs(input string tag);
    check({tag, "_ex"}, w_obs, 16'h0000);
    check({tag, "_stall"}, {15'd0, o_stall}, 16'h0000);
    check({tag, "_cnt"}, o_bubble_cnt, 16'h0000);
  endtask

  initial begin
    #5_000_000;
    $display("FAIL watchdog observed=timeout expected=finish");
    $fatal(1, "watchdog");
  end

  initial begin
    // reset held from time 0
    repeat (2) @(negedge i_clk);
    check_reset_outputs("por");
    i_arst = 1'b0; idle = 1'b1; exp_cnt = 16'd0;
    step("idle",     2'b00, F_LW,  5'd1, 5'd2, 5'd5, 1'b1, 1'b0, 1'b1);
    step("lw_x5",    2'b00, F_LW,  5'd1, 5'd2, 5'd5, 1'b1, 1'b0, 1'b0);
    step("add_hz",   2'b10, F_ADD, 5'd5, 5'd6, 5'd7, 1'b1, 1'b0, 1'b1);
    step("add_held", 2'b10, F_ADD, 5'd5, 5'd6, 5'd7, 1'b1, 1'b0, 1'b0);
    step("lw_x0",    2'b00, F_LW,  5'd3, 5'd4, 5'd0, 1'b1, 1'b0, 1'b0);
    step("add_x0",   2'b10, F_ADD, 5'd0, 5'd0, 5'd8, 1'b1, 1'b0, 1'b0);
    step("sw_flush", 2'b00, F_SW,  5'd2, 5'd9, 5'd0, 1'b1, 1'b1, 1'b0);
    step("lw_x5b",   2'b00, F_LW,  5'd1, 5'd2, 5'd5, 1'b1, 1'b0, 1'b0);
    step("collide",  2'b10, F_ADD, 5'd9, 5'd5, 5'd10, 1'b1, 1'b1, 1'b1);
    step("invalid",  2'b01, F_BEQ, 5'd5, 5'd5, 5'd3, 1'b0, 1'b0, 1'b0);
    step("lw_x5c",   2'b00, F_LW,  5'd1, 5'd2, 5'd5, 1'b1, 1'b0, 1'b0);
    step("add_rs2",  2'b10, F_ADD, 5'd11, 5'd5, 5'd12, 1'b1, 1'b0, 1'b1);

    // asynchronous reset mid-cycle (in STALL when hazard detection is built in)
    #2 i_arst = 1'b1;
    #1 check_reset_outputs("midrst");
    @(negedge i_clk);
    i_arst = 1'b0; idle = 1'b1; exp_cnt = 16'd0;
    step("idle2",    2'b10, F_ADD, 5'd11, 5'd5, 5'd12, 1'b1, 1'b0, 1'b0);

    // saturation: preload 65534 flush bubbles, then three counted flushes
    i_ex_flush = 1'b1;
    repeat (65534) @(posedge i_clk);
    #1 i_ex_flush = 1'b0;
    @(negedge i_clk);
    check("preload_cnt", o_bubble_cnt, 16'hFFFE);
    exp_cnt = 16'hFFFE;
    step("sat1", 2'b00, F_SW, 5'd2, 5'd9, 5'd0, 1'b1, 1'b1, 1'b0);
    step("sat2", 2'b00, F_SW, 5'd2, 5'd9, 5'd0, 1'b1, 1'b1, 1'b0);
    step("sat3", 2'b00, F_SW, 5'd2, 5'd9, 5'd0, 1'b1, 1'b1, 1'b0);
    step("post", 2'b10, F_ADD, 5'd1, 5'd2, 5'd3, 1'b1, 1'b0, 1'b0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
    $finish;
  end

endmodule
